// File: rtl/clk_phase_gen.sv
// clk_phase_gen
//   Derives the imem, dmem and processor/regfile clocks from one master
//   clock using a single free-running counter. Every divided clock is a
//   direct flop output, optionally OR-ed with the registered halt flop, so
//   the derived clocks are glitch-free.
//
//   Optional feature: define CLKGEN_STALL_EN to build the stall FSM
//   (RUN/DRAIN/HALT). With the FSM, stall_req freezes processor_clock and
//   regfile_clock high after the current processor cycle completes, and
//   stall_ack reports the frozen state. Without it, stall_req is ignored
//   and stall_ack is tied low.
//
// Parameters
//   IMEM_LOG2  imem divide exponent (0 = pass-through of clock)
//   DMEM_LOG2  dmem divide exponent
//   PROC_LOG2  processor divide exponent, 1..8, IMEM_LOG2 <= DMEM_LOG2 <= PROC_LOG2
//
// Ports
//   clock            master clock
//   reset            asynchronous active-high reset
//   stall_req        request to freeze processor/regfile clocks
//   stall_ack        high while processor/regfile clocks are frozen
//   imem_clock       non-inverted imem clock
//   dmem_clock       inverted divided dmem clock
//   processor_clock  inverted divided processor clock (held high on halt)
//   regfile_clock    copy of processor_clock
//   proc_tick        high in the last master cycle of each processor period
//   cycle_count      completed processor cycles (wraps)

module clk_phase_gen #(
  parameter int unsigned IMEM_LOG2 = 0,
  parameter int unsigned DMEM_LOG2 = 1,
  parameter int unsigned PROC_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_req,
  output logic        stall_ack,
  output logic        imem_clock,
  output logic        dmem_clock,
  output logic        processor_clock,
  output logic        regfile_clock,
  output logic        proc_tick,
  output logic [31:0] cycle_count
);

  localparam logic [PROC_LOG2-1:0] CNT_MAX = '1;

  logic [PROC_LOG2-1:0] cnt;
  logic                 halt;
  logic                 count_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PROC_LOG2'(1);
    end
  end

  assign proc_tick = (cnt == CNT_MAX);

  generate
    if (IMEM_LOG2 == 0) begin : g_imem_pass
      assign imem_clock = clock;
    end else begin : g_imem_div
      assign imem_clock = cnt[IMEM_LOG2-1];
    end

    if (DMEM_LOG2 == 0) begin : g_dmem_pass
      assign dmem_clock = ~clock;
    end else begin : g_dmem_div
      assign dmem_clock = ~cnt[DMEM_LOG2-1];
    end
  endgenerate

  // Only flop outputs feed the processor clock, so it cannot glitch.
  assign processor_clock = ~cnt[PROC_LOG2-1] | halt;
  assign regfile_clock   = processor_clock;

`ifdef CLKGEN_STALL_EN
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Leaving HALT on the edge where cnt becomes 2^(PROC_LOG2-1) lines the
  // release up with the natural falling edge of the processor clock.
  localparam logic [PROC_LOG2-1:0] RELEASE_PREV = PROC_LOG2'((2 ** (PROC_LOG2 - 1)) - 1);

  state_t state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stall_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Not cancellable: once draining, always finish into HALT.
          // halt rises with the final processor rising edge, holding it high.
          if (proc_tick) begin
            state <= HALT;
            halt  <= 1'b1;
          end
        end
        HALT: begin
          if (!stall_req && (cnt == RELEASE_PREV)) begin
            state <= RUN;
            halt  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          halt  <= 1'b0;
        end
      endcase
    end
  end

  // halt is set and cleared on exactly the HALT entry/exit edges.
  assign stall_ack = halt;
  assign count_en  = proc_tick && (state != HALT);
`else
  logic unused_stall_req;

  assign unused_stall_req = stall_req;
  assign halt             = 1'b0;
  assign stall_ack        = 1'b0;
  assign count_en         = proc_tick;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (count_en) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_clk_phase_gen.sv
// Testbench for clk_phase_gen with PROC_LOG2=2, DMEM_LOG2=1, IMEM_LOG2=0.
// Stall scenarios are built when CLKGEN_STALL_EN is defined; otherwise the
// bench checks that stall_req is ignored.

module tb_clk_phase_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall_req = 1'b0;
  logic        stall_ack;
  logic        imem_clock;
  logic        dmem_clock;
  logic        processor_clock;
  logic        regfile_clock;
  logic        proc_tick;
  logic [31:0] cycle_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_cnt = 0;

  clk_phase_gen #(
    .IMEM_LOG2(0),
    .DMEM_LOG2(1),
    .PROC_LOG2(2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .stall_req       (stall_req),
    .stall_ack       (stall_ack),
    .imem_clock      (imem_clock),
    .dmem_clock      (dmem_clock),
    .processor_clock (processor_clock),
    .regfile_clock   (regfile_clock),
    .proc_tick       (proc_tick),
    .cycle_count     (cycle_count)
  );

  always #5 clock = ~clock;

  // One master cycle: sample 1 time unit after the falling edge.
  task automatic step();
    @(negedge clock);
    #1;
    exp_cnt = (exp_cnt + 1) % 4;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (processor_clock !== 1'b1) begin n_bad++; $display("FAIL reset_proc got=%b exp=1", processor_clock); end
    n_cmp++; if (regfile_clock !== 1'b1) begin n_bad++; $display("FAIL reset_regfile got=%b exp=1", regfile_clock); end
    n_cmp++; if (dmem_clock !== 1'b1) begin n_bad++; $display("FAIL reset_dmem got=%b exp=1", dmem_clock); end
    n_cmp++; if (proc_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b exp=0", proc_tick); end
    n_cmp++; if (stall_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", stall_ack); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL reset_cycles got=%0d exp=0", cycle_count); end
    n_cmp++; if (imem_clock !== 1'b0) begin n_bad++; $display("FAIL reset_imem_lo got=%b exp=0", imem_clock); end
    // Across a rising edge while reset is held.
    @(posedge clock);
    #1;
    n_cmp++; if (imem_clock !== 1'b1) begin n_bad++; $display("FAIL reset_imem_hi got=%b exp=1", imem_clock); end
    n_cmp++; if (processor_clock !== 1'b1 || dmem_clock !== 1'b1) begin n_bad++; $display("FAIL reset_hold proc=%b dmem=%b exp=1/1", processor_clock, dmem_clock); end
    @(negedge clock);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_free_run();
    logic e_proc, e_dmem, e_tick;
    for (int k = 1; k <= 16; k++) begin
      step();
      e_proc = (exp_cnt < 2);
      e_dmem = (exp_cnt % 2 == 0);
      e_tick = (exp_cnt == 3);
      n_cmp++; if (processor_clock !== e_proc) begin n_bad++; $display("FAIL run_proc k=%0d got=%b exp=%b", k, processor_clock, e_proc); end
      n_cmp++; if (regfile_clock !== e_proc) begin n_bad++; $display("FAIL run_regfile k=%0d got=%b exp=%b", k, regfile_clock, e_proc); end
      n_cmp++; if (dmem_clock !== e_dmem) begin n_bad++; $display("FAIL run_dmem k=%0d got=%b exp=%b", k, dmem_clock, e_dmem); end
      n_cmp++; if (proc_tick !== e_tick) begin n_bad++; $display("FAIL run_tick k=%0d got=%b exp=%b", k, proc_tick, e_tick); end
      n_cmp++; if (cycle_count !== 32'(k / 4)) begin n_bad++; $display("FAIL run_cycles k=%0d got=%0d exp=%0d", k, cycle_count, k / 4); end
      n_cmp++; if (stall_ack !== 1'b0) begin n_bad++; $display("FAIL run_ack k=%0d got=%b exp=0", k, stall_ack); end
      n_cmp++; if (imem_clock !== 1'b0) begin n_bad++; $display("FAIL run_imem_lo k=%0d got=%b exp=0", k, imem_clock); end
    end
    @(posedge clock);
    #1;
    n_cmp++; if (imem_clock !== 1'b1) begin n_bad++; $display("FAIL run_imem_hi got=%b exp=1", imem_clock); end
    @(negedge clock);
    #1;
    exp_cnt = (exp_cnt + 1) % 4;
  endtask

  // Reset arriving at cnt=2 clears everything without a clock edge.
  task automatic test_mid_reset();
    apply_reset();
    for (int k = 0; k < 6; k++) step();
    n_cmp++; if (processor_clock !== 1'b0 || cycle_count !== 32'd1) begin n_bad++; $display("FAIL mid_pre proc=%b cycles=%0d exp=0/1", processor_clock, cycle_count); end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (processor_clock !== 1'b1) begin n_bad++; $display("FAIL mid_proc got=%b exp=1", processor_clock); end
    n_cmp++; if (regfile_clock !== 1'b1) begin n_bad++; $display("FAIL mid_regfile got=%b exp=1", regfile_clock); end
    n_cmp++; if (dmem_clock !== 1'b1) begin n_bad++; $display("FAIL mid_dmem got=%b exp=1", dmem_clock); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL mid_cycles got=%0d exp=0", cycle_count); end
    n_cmp++; if (proc_tick !== 1'b0 || stall_ack !== 1'b0) begin n_bad++; $display("FAIL mid_tick_ack tick=%b ack=%b exp=0/0", proc_tick, stall_ack); end
    @(negedge clock);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
  endtask

`ifdef CLKGEN_STALL_EN
  task automatic test_stall();
    // Expected {ack, proc, cycles} after each step from stall_req at cnt=1.
    logic        e_ack [3]  = '{1'b0, 1'b0, 1'b1};
    logic        e_proc [3] = '{1'b0, 1'b0, 1'b1};
    int unsigned e_cyc [3]  = '{0, 0, 1};
    logic        r_ack [4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        r_proc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int unsigned r_cyc [4]  = '{1, 1, 1, 2};
    apply_reset();
    step();
    stall_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (stall_ack !== e_ack[i] || processor_clock !== e_proc[i] || cycle_count !== 32'(e_cyc[i]))
        begin n_bad++; $display("FAIL stall_enter i=%0d ack=%b proc=%b cyc=%0d exp=%b/%b/%0d", i, stall_ack, processor_clock, cycle_count, e_ack[i], e_proc[i], e_cyc[i]); end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++; if (stall_ack !== 1'b1 || processor_clock !== 1'b1 || regfile_clock !== 1'b1 || cycle_count !== 32'd1)
        begin n_bad++; $display("FAIL stall_hold i=%0d ack=%b proc=%b rf=%b cyc=%0d exp=1/1/1/1", i, stall_ack, processor_clock, regfile_clock, cycle_count); end
      n_cmp++; if (dmem_clock !== (exp_cnt % 2 == 0)) begin n_bad++; $display("FAIL stall_dmem i=%0d got=%b exp=%b", i, dmem_clock, exp_cnt % 2 == 0); end
    end
    stall_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (stall_ack !== r_ack[i] || processor_clock !== r_proc[i] || cycle_count !== 32'(r_cyc[i]))
        begin n_bad++; $display("FAIL stall_release i=%0d ack=%b proc=%b cyc=%0d exp=%b/%b/%0d", i, stall_ack, processor_clock, cycle_count, r_ack[i], r_proc[i], r_cyc[i]); end
    end
  endtask

  task automatic test_drain_cancel();
    logic        e_ack [6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        e_proc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int unsigned e_cyc [6]  = '{0, 1, 1, 1, 1, 2};
    apply_reset();
    step();
    stall_req = 1'b1;
    step();
    stall_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (stall_ack !== e_ack[i] || processor_clock !== e_proc[i] || cycle_count !== 32'(e_cyc[i]))
        begin n_bad++; $display("FAIL drain_cancel i=%0d ack=%b proc=%b cyc=%0d exp=%b/%b/%0d", i, stall_ack, processor_clock, cycle_count, e_ack[i], e_proc[i], e_cyc[i]); end
    end
  endtask

  task automatic test_reset_in_halt();
    apply_reset();
    stall_req = 1'b1;
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (stall_ack !== 1'b1) begin n_bad++; $display("FAIL halt_pre ack=%b exp=1", stall_ack); end
    stall_req = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++; if (stall_ack !== 1'b0 || cycle_count !== 32'd0) begin n_bad++; $display("FAIL halt_reset ack=%b cyc=%0d exp=0/0", stall_ack, cycle_count); end
    @(negedge clock);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (processor_clock !== 1'b1 || stall_ack !== 1'b0 || cycle_count !== 32'd1)
      begin n_bad++; $display("FAIL halt_restart proc=%b ack=%b cyc=%0d exp=1/0/1", processor_clock, stall_ack, cycle_count); end
    step();
    step();
    n_cmp++; if (processor_clock !== 1'b0) begin n_bad++; $display("FAIL halt_restart_low proc=%b exp=0", processor_clock); end
  endtask
`else
  task automatic test_no_stall();
    logic e_proc;
    apply_reset();
    stall_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      e_proc = (exp_cnt < 2);
      n_cmp++; if (processor_clock !== e_proc || stall_ack !== 1'b0 || cycle_count !== 32'(k / 4))
        begin n_bad++; $display("FAIL no_stall k=%0d proc=%b ack=%b cyc=%0d exp=%b/0/%0d", k, processor_clock, stall_ack, cycle_count, e_proc, k / 4); end
    end
    stall_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_mid_reset();
`ifdef CLKGEN_STALL_EN
    test_stall();
    test_drain_cancel();
    test_reset_in_halt();
`else
    test_no_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
